// File: rtl/zap_data_bus_if_pkg.sv
// Shared types for the data-side bus master: FSM states, access size codes, size decode.
package zap_data_bus_if_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, FLUSH, DONE} state_e;

  typedef enum logic [1:0] {SEL_BYTE, SEL_HALF, SEL_WORD} size_e;

  // Byte flags win over half flags; no flag at all means a word access.
  function automatic size_e size_decode(input logic ubyte, input logic sbyte,
                                        input logic shalf, input logic uhalf);
    if (ubyte || sbyte)      return SEL_BYTE;
    else if (shalf || uhalf) return SEL_HALF;
    else                     return SEL_WORD;
  endfunction

endpackage

// File: rtl/zap_data_bus_if_if.sv
// ALU-stage request, Wishbone classic master signals and memory-stage response in one bundle.
interface zap_data_bus_if_if;
  logic        i_clear_from_writeback;
  logic        i_mem_load_ff;
  logic        i_mem_store_ff;
  logic [31:0] i_mem_address_ff;
  logic [31:0] i_mem_srcdest_value_ff;
  logic        i_sbyte_ff;
  logic        i_ubyte_ff;
  logic        i_shalf_ff;
  logic        i_uhalf_ff;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic        o_data_stall;
  logic [31:0] o_mem_rd_data;
  logic        o_mem_fault;

  modport master (
    input  i_clear_from_writeback, i_mem_load_ff, i_mem_store_ff, i_mem_address_ff,
           i_mem_srcdest_value_ff, i_sbyte_ff, i_ubyte_ff, i_shalf_ff, i_uhalf_ff,
           i_wb_dat, i_wb_ack, i_wb_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
           o_data_stall, o_mem_rd_data, o_mem_fault
  );

  modport slave (
    output i_clear_from_writeback, i_mem_load_ff, i_mem_store_ff, i_mem_address_ff,
           i_mem_srcdest_value_ff, i_sbyte_ff, i_ubyte_ff, i_shalf_ff, i_uhalf_ff,
           i_wb_dat, i_wb_ack, i_wb_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
           o_data_stall, o_mem_rd_data, o_mem_fault
  );
endinterface

// File: rtl/zap_data_bus_if_lane_gen.sv
// Byte-lane enables, replicated store data and alignment check for one access.
module zap_dbus_lane_gen
  import zap_data_bus_if_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_load,
  input  logic [31:0] value,
  output logic [3:0]  sel,
  output logic [31:0] dat,
  output logic        misaligned
);

  always_comb begin
    sel        = 4'b0000;
    dat        = '0;
    misaligned = 1'b0;
    case (size)
      SEL_BYTE: begin
        sel = 4'b0001 << addr_lo;
        dat = {4{value[7:0]}};
      end
      SEL_HALF: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        dat        = {2{value[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        sel        = 4'b1111;
        dat        = value;
        misaligned = |addr_lo;
      end
    endcase
    // Loads keep the lane enables but never drive write data.
    if (is_load) dat = '0;
  end

endmodule

// File: rtl/zap_data_bus_if.sv
// Data-side Wishbone classic master: one bus cycle per ALU-stage load/store, with
// pipeline stall, timeout, flush handling and a one-cycle DONE handoff to the memory stage.
module zap_data_bus_if
  import zap_data_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  zap_data_bus_if_if.master  bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  size_e            size;
  logic [3:0]       lane_sel;
  logic [31:0]      lane_dat;
  logic             misaligned, mis_fault, req, timeout, term;

  assign size = size_decode(bus.i_ubyte_ff, bus.i_sbyte_ff, bus.i_shalf_ff, bus.i_uhalf_ff);

  zap_dbus_lane_gen u_lane (
    .addr_lo    (bus.i_mem_address_ff[1:0]),
    .size       (size),
    .is_load    (bus.i_mem_load_ff),
    .value      (bus.i_mem_srcdest_value_ff),
    .sel        (lane_sel),
    .dat        (lane_dat),
    .misaligned (misaligned)
  );

  assign req       = (bus.i_mem_load_ff || bus.i_mem_store_ff) && !bus.i_clear_from_writeback;
  assign mis_fault = misaligned && ALIGN_CHECK;
  // The counter reads k-1 in the k-th ACCESS cycle, so the last allowed cycle is CNT_LAST.
  assign timeout   = (cnt == CNT_LAST);
  assign term      = bus.i_wb_ack || bus.i_wb_err || timeout;

  assign bus.o_data_stall = (state == IDLE && req) || state == ACCESS || state == FLUSH;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = mis_fault ? DONE : ACCESS;
      ACCESS: begin
        // A flush landing on the terminating cycle discards the result like FLUSH does.
        if (term)                            state_nxt = bus.i_clear_from_writeback ? IDLE : DONE;
        else if (bus.i_clear_from_writeback) state_nxt = FLUSH;
      end
      FLUSH:   if (term) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bus.o_wb_cyc      <= 1'b0;
      bus.o_wb_stb      <= 1'b0;
      bus.o_wb_we       <= 1'b0;
      bus.o_wb_adr      <= '0;
      bus.o_wb_sel      <= '0;
      bus.o_wb_dat      <= '0;
      bus.o_mem_rd_data <= '0;
      bus.o_mem_fault   <= 1'b0;
      cnt               <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (mis_fault) begin
            bus.o_mem_fault   <= 1'b1;
            bus.o_mem_rd_data <= '0;
          end else begin
            bus.o_wb_cyc <= 1'b1;
            bus.o_wb_stb <= 1'b1;
            bus.o_wb_we  <= !bus.i_mem_load_ff;
            bus.o_wb_adr <= {bus.i_mem_address_ff[31:2], 2'b00};
            bus.o_wb_sel <= lane_sel;
            bus.o_wb_dat <= lane_dat;
            cnt          <= '0;
          end
        end
        ACCESS, FLUSH: begin
          cnt <= cnt + CNT_W'(1);
          if (term) begin
            bus.o_wb_cyc <= 1'b0;
            bus.o_wb_stb <= 1'b0;
            bus.o_wb_we  <= 1'b0;
            bus.o_wb_sel <= '0;
            if (state == FLUSH || bus.i_clear_from_writeback) begin
              bus.o_mem_fault <= 1'b0;
            end else if (bus.i_wb_err) begin
              bus.o_mem_fault   <= 1'b1;
              bus.o_mem_rd_data <= '0;
            end else if (bus.i_wb_ack) begin
              bus.o_mem_fault   <= 1'b0;
              bus.o_mem_rd_data <= bus.o_wb_we ? 32'h0 : bus.i_wb_dat;
            end else begin
              bus.o_mem_fault   <= 1'b1;
              bus.o_mem_rd_data <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_data_bus_if.sv
// Bench for zap_data_bus_if: vector table, corner-case sequences and random transactions vs a lane/timing model.
module tb_zap_data_bus_if;

  localparam int TO = 4;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b1;
  logic bn_ack = 1'b0;
  int   checks = 0;
  int   failures = 0;

  zap_data_bus_if_if bi ();
  zap_data_bus_if_if bn ();

  // Second instance (no alignment check, longer timeout) sees the same request but its own ack.
  assign bn.i_clear_from_writeback = bi.i_clear_from_writeback;
  assign bn.i_mem_load_ff          = bi.i_mem_load_ff;
  assign bn.i_mem_store_ff         = bi.i_mem_store_ff;
  assign bn.i_mem_address_ff       = bi.i_mem_address_ff;
  assign bn.i_mem_srcdest_value_ff = bi.i_mem_srcdest_value_ff;
  assign bn.i_sbyte_ff             = bi.i_sbyte_ff;
  assign bn.i_ubyte_ff             = bi.i_ubyte_ff;
  assign bn.i_shalf_ff             = bi.i_shalf_ff;
  assign bn.i_uhalf_ff             = bi.i_uhalf_ff;
  assign bn.i_wb_dat               = bi.i_wb_dat;
  assign bn.i_wb_ack               = bn_ack;
  assign bn.i_wb_err               = 1'b0;

  zap_data_bus_if #(.TIMEOUT_CYCLES(TO), .ALIGN_CHECK(1'b1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bi));
  zap_data_bus_if #(.TIMEOUT_CYCLES(16), .ALIGN_CHECK(1'b0)) dut_n (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bn));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic ld, st, ub, sb, sh, uh;
    logic [31:0] a, v, rdat;
    logic mis;
    logic [3:0] sel;
    logic [31:0] adr, dat;
    logic we;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input logic ld, st, ub, sb, sh, uh, input logic [31:0] a, v);
    bi.i_mem_load_ff = ld;  bi.i_mem_store_ff = st;
    bi.i_ubyte_ff = ub;     bi.i_sbyte_ff = sb;
    bi.i_shalf_ff = sh;     bi.i_uhalf_ff = uh;
    bi.i_mem_address_ff = a; bi.i_mem_srcdest_value_ff = v;
  endtask

  task automatic idle_req;
    drive_req(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    bi.i_clear_from_writeback = 1'b0;
  endtask

  // Lane model: an n-byte access occupies the n-byte group holding the address,
  // and each lane carries store byte (lane mod n).
  function automatic void ref_lane(input logic ld, ub, sb, sh, uh, input logic [31:0] a, v,
                                   output logic [3:0] s, output logic [31:0] d, output logic mis);
    int n, off;
    n   = (ub || sb) ? 1 : (sh || uh) ? 2 : 4;
    off = int'(a[1:0]);
    mis = (off % n) != 0;
    for (int i = 0; i < 4; i++) begin
      s[i]        = (i / n) == (off / n);
      d[8*i +: 8] = ld ? 8'h00 : v[8*(i % n) +: 8];
    end
  endfunction

  // One transaction on the checked instance; response arrives in ACCESS cycle w+1.
  task automatic run_txn(input logic ld, st, ub, sb, sh, uh, input logic [31:0] a, v, rdat,
                         input int w, input bit e_only, input bit both);
    logic [3:0]  es;
    logic [31:0] ed, er;
    logic        mis, ef;
    int          t_end;
    bit          resolved;
    ref_lane(ld, ub, sb, sh, uh, a, v, es, ed, mis);
    resolved = (w + 1) <= TO;
    t_end    = resolved ? w + 1 : TO;
    ef       = mis || !resolved || e_only || both;
    er       = (!ef && ld) ? rdat : 32'h0;
    drive_req(ld, st, ub, sb, sh, uh, a, v);
    bi.i_wb_dat = rdat; bi.i_wb_ack = 1'b0; bi.i_wb_err = 1'b0;
    #1 chk("stall_on_req", bi.o_data_stall, 1);
    if (!mis) begin
      for (int k = 1; k <= t_end; k++) begin
        tick;
        chk("cyc_in_access", bi.o_wb_cyc, 1);
        chk("stall_in_access", bi.o_data_stall, 1);
        if (k == 1) begin
          chk("adr", bi.o_wb_adr, a & 32'hFFFF_FFFC);
          chk("sel", bi.o_wb_sel, es);
          chk("dat", bi.o_wb_dat, ed);
          chk("we", bi.o_wb_we, !ld);
        end
        if (k == w + 1) begin
          bi.i_wb_ack = !e_only;
          bi.i_wb_err = e_only || both;
        end
      end
    end
    tick;
    chk("done_cyc", bi.o_wb_cyc, 0);
    chk("done_stall", bi.o_data_stall, 0);
    chk("done_fault", bi.o_mem_fault, ef);
    chk("done_rd_data", bi.o_mem_rd_data, er);
    chk("done_sel", bi.o_wb_sel, 0);
    idle_req;
    bi.i_wb_ack = 1'b0; bi.i_wb_err = 1'b0;
    tick;
  endtask

  initial begin
    idle_req;
    bi.i_wb_dat = 32'h0; bi.i_wb_ack = 1'b0; bi.i_wb_err = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_cyc", bi.o_wb_cyc, 0);
    chk("rst_stb", bi.o_wb_stb, 0);
    chk("rst_adr", bi.o_wb_adr, 0);
    chk("rst_rd_data", bi.o_mem_rd_data, 0);
    chk("rst_fault", bi.o_mem_fault, 0);
    chk("rst_stall", bi.o_data_stall, 0);
    tick; tick;
    i_reset_n = 1'b1;
    tick;

    //         ld st ub sb sh uh  a          v             rdat          mis sel      adr          dat           we
    tbl[0] = '{1, 0, 0, 0, 0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h100, 32'h0,        0};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 32'h203, 32'hA5,       32'h11111111, 0, 4'b1000, 32'h200, 32'hA5A5A5A5, 1};
    tbl[2] = '{1, 0, 0, 0, 0, 1, 32'h101, 32'h0,        32'hCAFE0000, 1, 4'b0011, 32'h100, 32'h0,        0};
    tbl[3] = '{1, 1, 0, 0, 0, 0, 32'h40,  32'h12345678, 32'h0BADF00D, 0, 4'b1111, 32'h40,  32'h0,        0};
    tbl[4] = '{0, 1, 0, 1, 0, 0, 32'h1,   32'h123456C3, 32'h22222222, 0, 4'b0010, 32'h0,   32'hC3C3C3C3, 1};
    tbl[5] = '{0, 1, 0, 0, 1, 0, 32'hFE,  32'hBEEF1234, 32'h33333333, 0, 4'b1100, 32'hFC,  32'h12341234, 1};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 32'h2,   32'h55AA55AA, 32'h44444444, 1, 4'b1111, 32'h0,   32'h55AA55AA, 1};
    tbl[7] = '{1, 0, 1, 0, 0, 1, 32'h12,  32'h0,        32'h77665544, 0, 4'b0100, 32'h10,  32'h0,        0};
    tbl[8] = '{0, 1, 0, 0, 0, 1, 32'h302, 32'hFFFF8001, 32'h55555555, 0, 4'b1100, 32'h300, 32'h80018001, 1};

    foreach (tbl[i]) begin
      drive_req(tbl[i].ld, tbl[i].st, tbl[i].ub, tbl[i].sb, tbl[i].sh, tbl[i].uh, tbl[i].a, tbl[i].v);
      bi.i_wb_dat = tbl[i].rdat; bi.i_wb_ack = 1'b1; bn_ack = 1'b1;
      #1 chk("tv_stall_req", bi.o_data_stall, 1);
      tick;
      if (tbl[i].mis) begin
        chk("tv_mis_cyc", bi.o_wb_cyc, 0);
        chk("tv_mis_stall", bi.o_data_stall, 0);
        chk("tv_mis_fault", bi.o_mem_fault, 1);
        chk("tv_mis_rd", bi.o_mem_rd_data, 0);
        chk("tv_noalign_cyc", bn.o_wb_cyc, 1);
        chk("tv_noalign_sel", bn.o_wb_sel, tbl[i].sel);
        chk("tv_noalign_adr", bn.o_wb_adr, tbl[i].adr);
        idle_req;
      end else begin
        chk("tv_cyc", bi.o_wb_cyc, 1);
        chk("tv_stb", bi.o_wb_stb, 1);
        chk("tv_we", bi.o_wb_we, tbl[i].we);
        chk("tv_adr", bi.o_wb_adr, tbl[i].adr);
        chk("tv_sel", bi.o_wb_sel, tbl[i].sel);
        chk("tv_dat", bi.o_wb_dat, tbl[i].dat);
        chk("tv_stall_access", bi.o_data_stall, 1);
      end
      tick;
      if (!tbl[i].mis) begin
        chk("tv_done_stall", bi.o_data_stall, 0);
        chk("tv_done_cyc", bi.o_wb_cyc, 0);
        chk("tv_done_fault", bi.o_mem_fault, 0);
        chk("tv_done_rd", bi.o_mem_rd_data, tbl[i].ld ? tbl[i].rdat : 32'h0);
      end
      idle_req;
      bi.i_wb_ack = 1'b0; bn_ack = 1'b0;
      tick;
    end

    // Timeout with no response, ack in the last allowed cycle, ack+err together.
    run_txn(1, 0, 0, 0, 0, 0, 32'h80, 32'h0, 32'h11223344, 10, 0, 0);
    run_txn(1, 0, 0, 0, 0, 0, 32'h84, 32'h0, 32'h99887766, 3, 0, 0);
    run_txn(1, 0, 0, 0, 0, 0, 32'h88, 32'h0, 32'hFFFFFFFF, 1, 0, 1);
    run_txn(0, 1, 0, 0, 0, 0, 32'h8C, 32'h1, 32'hFFFFFFFF, 0, 1, 0);

    for (int i = 0; i < 20; i++) tick;

    // Flush on the second ACCESS cycle of the long-timeout instance.
    drive_req(1, 0, 0, 0, 0, 0, 32'h500, 32'h0);
    bi.i_wb_dat = 32'h12345678;
    tick; tick;
    bi.i_clear_from_writeback = 1'b1;
    drive_req(0, 0, 0, 0, 0, 0, 32'h500, 32'h0);
    #1 chk("fl_stall_clear", bn.o_data_stall, 1);
    tick;
    bi.i_clear_from_writeback = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("fl_cyc_held", bn.o_wb_cyc, 1);
      chk("fl_stall_held", bn.o_data_stall, 1);
      if (k == 2) bn_ack = 1'b1;
      if (k < 2) tick;
    end
    tick;
    bn_ack = 1'b0;
    chk("fl_cyc_end", bn.o_wb_cyc, 0);
    chk("fl_stall_end", bn.o_data_stall, 0);
    chk("fl_fault", bn.o_mem_fault, 0);
    drive_req(0, 1, 1, 0, 0, 0, 32'h7, 32'h3C);
    #1 chk("fl_no_done", bn.o_data_stall, 1);
    tick;
    chk("fl_next_cyc", bn.o_wb_cyc, 1);
    chk("fl_next_sel", bn.o_wb_sel, 4'b1000);
    chk("fl_next_adr", bn.o_wb_adr, 32'h4);
    chk("fl_next_dat", bn.o_wb_dat, 32'h3C3C3C3C);
    chk("fl_next_we", bn.o_wb_we, 1);
    bn_ack = 1'b1;
    tick;
    bn_ack = 1'b0;
    chk("fl_next_done_stall", bn.o_data_stall, 0);
    chk("fl_next_done_fault", bn.o_mem_fault, 0);
    chk("fl_next_done_rd", bn.o_mem_rd_data, 0);
    idle_req;
    for (int i = 0; i < 6; i++) tick;

    // Asynchronous reset in the middle of a bus cycle.
    run_txn(1, 0, 0, 0, 0, 0, 32'h600, 32'h0, 32'h13572468, 0, 0, 0);
    drive_req(1, 0, 0, 0, 0, 0, 32'h604, 32'h0);
    tick;
    chk("rm_cyc_before", bi.o_wb_cyc, 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("rm_cyc", bi.o_wb_cyc, 0);
    chk("rm_stb", bi.o_wb_stb, 0);
    chk("rm_rd_data", bi.o_mem_rd_data, 0);
    idle_req;
    #1 chk("rm_stall", bi.o_data_stall, 0);
    tick;
    i_reset_n = 1'b1;
    tick;

    for (int t = 0; t < 60; t++) begin
      logic ld, st, ub, sb, sh, uh;
      logic [31:0] a, v, rd;
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      ub = ($urandom_range(0, 3) == 0); sb = ($urandom_range(0, 3) == 0);
      sh = ($urandom_range(0, 3) == 0); uh = ($urandom_range(0, 3) == 0);
      a = $urandom; v = $urandom; rd = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        drive_req(ld, st, ub, sb, sh, uh, a, v);
        bi.i_clear_from_writeback = 1'b1;
        #1 chk("rnd_clear_stall", bi.o_data_stall, 0);
        tick;
        chk("rnd_clear_cyc", bi.o_wb_cyc, 0);
        idle_req;
        tick;
      end else begin
        run_txn(ld, st, ub, sb, sh, uh, a, v, rd, int'($urandom_range(0, 5)),
                $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      end
    end

    for (int i = 0; i < 20; i++) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
